// File: rtl/bfp_pkg.sv
// Shared types and FP32 constants for the BFP block MAC.
// Holds the FSM state enum used by bfp_block_mac.
package bfp_pkg;

  localparam int FP32_W      = 32;
  localparam int FP32_FRAC_W = 23;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_BIAS   = 127;

  localparam logic [FP32_W-1:0] FP32_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    CONVERT,
    OUTPUT
  } bfp_mac_state_t;

endpackage

// File: rtl/bfp_block_mac_if.sv
// Beat input and FP32 result handshake bundle for bfp_block_mac.
// master: beat producer / result consumer; slave: the MAC.
interface bfp_block_mac_if #(
  parameter int LANES  = 4,
  parameter int MANT_W = 8,
  parameter int EXP_W  = 8
);

  logic                      in_valid;
  logic                      in_ready;
  logic                      in_last;
  logic [EXP_W-1:0]          in_exp_a;
  logic [EXP_W-1:0]          in_exp_b;
  logic [LANES*MANT_W-1:0]   in_mant_a;
  logic [LANES*MANT_W-1:0]   in_mant_b;
  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_result;
  logic                      out_overflow;

  modport master (
    output in_valid, in_last, in_exp_a, in_exp_b,
    output in_mant_a, in_mant_b, out_ready,
    input  in_ready, out_valid, out_result, out_overflow
  );

  modport slave (
    input  in_valid, in_last, in_exp_a, in_exp_b,
    input  in_mant_a, in_mant_b, out_ready,
    output in_ready, out_valid, out_result, out_overflow
  );

endinterface

// File: rtl/bfp_fp32_normalizer.sv
// Combinational signed fixed-point (acc x 2^acc_exp) to FP32 packer.
// Ports: acc, acc_exp in; result (FP32), overflow out. BFP_MAC_RNE_EN: RNE.
module bfp_fp32_normalizer
  import bfp_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int EW    = 10
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [EW-1:0]    acc_exp,
  output logic [FP32_W-1:0]       result,
  output logic                    overflow
);

  localparam int E_MAX = (1 << FP32_EXP_W) - 2;

  logic                   sign;
  logic [ACC_W-1:0]       mag;
  logic [ACC_W-1:0]       norm;
  logic [ACC_W+23:0]      ext;
  logic [FP32_FRAC_W-1:0] frac;
  int                     p;
  int                     e;
`ifdef BFP_MAC_RNE_EN
  logic [FP32_FRAC_W:0]   rnd;
`endif

  always_comb begin
    sign = acc[ACC_W-1];
    mag  = sign ? -acc : acc;
    p    = 0;
    for (int i = 0; i < ACC_W; i++) begin
      if (mag[i]) p = i;
    end
    // leading one moved to the MSB; the bits under it form the fraction
    norm = mag << (ACC_W - 1 - p);
    ext  = {norm, 24'd0};
    frac = FP32_FRAC_W'(ext >> ACC_W);
    e    = int'(acc_exp) + p + FP32_BIAS;
`ifdef BFP_MAC_RNE_EN
    rnd = '0;
    if (ext[ACC_W-1] && ((|ext[ACC_W-2:0]) || frac[0])) begin
      rnd  = {1'b0, frac} + 1'b1;
      frac = rnd[FP32_FRAC_W-1:0];
      if (rnd[FP32_FRAC_W]) e = e + 1;
    end
`endif
    result   = '0;
    overflow = 1'b0;
    if (mag == '0) begin
      result = '0;
    end else if (e > E_MAX) begin
      result   = FP32_INF | {sign, 31'd0};
      overflow = 1'b1;
    end else if (e < 1) begin
      result = {sign, 31'd0};
    end else begin
      result = {sign, FP32_EXP_W'(e), frac};
    end
  end

endmodule

// File: rtl/bfp_block_mac.sv
// BFP block dot-product accumulator with FP32 group result output.
// Ports: clk, rst_n, bus (slave). Optional BFP_MAC_RNE_EN rounding.
module bfp_block_mac
  import bfp_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int MANT_W   = 8,
  parameter int EXP_W    = 8,
  parameter int EXP_BIAS = 127,
  parameter int ACC_W    = 32
) (
  input logic            clk,
  input logic            rst_n,
  bfp_block_mac_if.slave bus
);

  localparam int PW = 2 * MANT_W + $clog2(LANES);
  localparam int EW = EXP_W + 2;

  localparam logic signed [ACC_W:0] SMAX =
    {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SMIN = -SMAX;

  generate
    if (ACC_W < PW) begin : g_acc_chk
      $error("ACC_W too narrow for the lane product sum");
    end
  endgenerate

  bfp_mac_state_t state, nxt;

  logic                    accept;
  logic signed [PW-1:0]    psum_c;
  logic signed [EW-1:0]    pexp_c;
  logic                    p_valid;
  logic                    p_first;
  logic signed [PW-1:0]    p_sum;
  logic signed [EW-1:0]    p_exp;
  logic signed [ACC_W-1:0] acc;
  logic signed [EW-1:0]    acc_exp;
  logic                    ovf;
  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] a_sh;
  logic signed [ACC_W-1:0] b_sh;
  logic signed [ACC_W-1:0] acc_n;
  logic signed [EW-1:0]    exp_n;
  logic signed [EW:0]      dexp;
  logic signed [ACC_W:0]   sum;
  logic                    of_c;
  int                      sh;
  logic [31:0]             n_res;
  logic                    n_ovf;
  logic [31:0]             res_q;
  logic                    ovf_q;

  assign bus.in_ready = (state == IDLE) || (state == ACCUM);
  assign bus.out_valid = (state == OUTPUT);
  assign bus.out_result = res_q;
  assign bus.out_overflow = ovf_q;
  assign accept = bus.in_valid & bus.in_ready;

  always_comb begin
    logic signed [2*MANT_W-1:0] ma, mb, pr;
    psum_c = '0;
    for (int i = 0; i < LANES; i++) begin
      ma = (2*MANT_W)'(signed'(bus.in_mant_a[i*MANT_W +: MANT_W]));
      mb = (2*MANT_W)'(signed'(bus.in_mant_b[i*MANT_W +: MANT_W]));
      pr = ma * mb;
      psum_c = psum_c + PW'(pr);
    end
    pexp_c = EW'(bus.in_exp_a) + EW'(bus.in_exp_b)
           - EW'(2 * EXP_BIAS);
  end

  // align to the larger exponent, then saturating add
  always_comb begin
    p_ext = ACC_W'(p_sum);
    dexp  = (EW+1)'(p_exp) - (EW+1)'(acc_exp);
    sh    = (dexp > 0) ? int'(dexp) : -int'(dexp);
    if (sh > ACC_W - 1) sh = ACC_W - 1;
    if (dexp > 0) begin
      a_sh  = acc >>> sh;
      b_sh  = p_ext;
      exp_n = p_exp;
    end else begin
      a_sh  = acc;
      b_sh  = p_ext >>> sh;
      exp_n = acc_exp;
    end
    sum   = (ACC_W+1)'(a_sh) + (ACC_W+1)'(b_sh);
    of_c  = 1'b0;
    acc_n = sum[ACC_W-1:0];
    if (sum > SMAX) begin
      acc_n = SMAX[ACC_W-1:0];
      of_c  = 1'b1;
    end else if (sum < SMIN) begin
      acc_n = SMIN[ACC_W-1:0];
      of_c  = 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = bus.in_last ? CONVERT : ACCUM;
      ACCUM:   if (accept && bus.in_last) nxt = CONVERT;
      CONVERT: if (!p_valid) nxt = OUTPUT;
      OUTPUT:  if (bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_sum   <= '0;
      p_exp   <= '0;
      acc     <= '0;
      acc_exp <= '0;
      ovf     <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_sum   <= psum_c;
        p_exp   <= pexp_c;
        p_first <= (state == IDLE);
      end
      if (p_valid) begin
        if (p_first) begin
          acc     <= p_ext;
          acc_exp <= p_exp;
        end else begin
          acc     <= acc_n;
          acc_exp <= exp_n;
          ovf     <= ovf | of_c;
        end
      end
      // convert only once the last product has been folded in
      if (state == CONVERT && !p_valid) begin
        res_q <= n_res;
        ovf_q <= ovf | n_ovf;
      end
      if (state == OUTPUT && bus.out_ready) ovf <= 1'b0;
    end
  end

  bfp_fp32_normalizer #(
    .ACC_W(ACC_W),
    .EW   (EW)
  ) u_norm (
    .acc     (acc),
    .acc_exp (acc_exp),
    .result  (n_res),
    .overflow(n_ovf)
  );

endmodule

// File: tb/tb_bfp_block_mac.sv
// Directed self-checking bench for bfp_block_mac.
// Second instance (MANT_W=16, ACC_W=40) covers fraction rounding.
module tb_bfp_block_mac;

  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rnd;

  always #5 clk = ~clk;

  bfp_block_mac_if #(.LANES(4), .MANT_W(8), .EXP_W(8)) m ();
  bfp_block_mac_if #(.LANES(4), .MANT_W(16), .EXP_W(8)) r ();

  bfp_block_mac #(
    .LANES(4), .MANT_W(8), .EXP_W(8), .EXP_BIAS(127), .ACC_W(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (m)
  );

  bfp_block_mac #(
    .LANES(4), .MANT_W(16), .EXP_W(8), .EXP_BIAS(127), .ACC_W(40)
  ) dut_r (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (r)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] ea, input logic [7:0] eb,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic last);
    int n = 0;
    m.in_exp_a  = ea;
    m.in_exp_b  = eb;
    m.in_mant_a = a;
    m.in_mant_b = b;
    m.in_last   = last;
    m.in_valid  = 1'b1;
    while (!m.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("accept_wait", 32'(m.in_ready), 32'd1);
    tick();
    m.in_valid = 1'b0;
    m.in_last  = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [31:0] er,
                          input logic eo);
    int n = 0;
    while (!m.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(m.out_valid), 32'd1);
    chk(tag, m.out_result, er);
    chk({tag, "_ovf"}, 32'(m.out_overflow), 32'(eo));
    tick();
  endtask

  initial begin
    rst_n = 1'b1;
    m.in_valid = 0; m.in_last = 0; m.in_exp_a = 0; m.in_exp_b = 0;
    m.in_mant_a = 0; m.in_mant_b = 0; m.out_ready = 1;
    r.in_valid = 0; r.in_last = 0; r.in_exp_a = 0; r.in_exp_b = 0;
    r.in_mant_a = 0; r.in_mant_b = 0; r.out_ready = 1;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_out_valid", 32'(m.out_valid), 32'd0);
    chk("rst_result", m.out_result, 32'd0);
    chk("rst_ovf", 32'(m.out_overflow), 32'd0);
    chk("rst_in_ready", 32'(m.in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // 1+2+3+4 = 10.0, latency check
    beat(8'd127, 8'd127, 32'h04030201, 32'h01010101, 1'b1);
    chk("lat_in_ready", 32'(m.in_ready), 32'd0);
    chk("lat_t1", 32'(m.out_valid), 32'd0);
    tick();
    chk("lat_t2", 32'(m.out_valid), 32'd0);
    tick();
    chk("lat_t3", 32'(m.out_valid), 32'd1);
    wait_out("single", 32'h41200000, 1'b0);
    chk("valid_drop", 32'(m.out_valid), 32'd0);

    // 4*2^0 + 1*2^1 = 6.0, back-to-back beats
    beat(8'd127, 8'd127, 32'h01010101, 32'h01010101, 1'b0);
    beat(8'd128, 8'd127, 32'h00000001, 32'h00000001, 1'b1);
    wait_out("two_beat", 32'h40C00000, 1'b0);

    beat(8'd127, 8'd127, 32'h000000FF, 32'h00000003, 1'b1);
    wait_out("negative", 32'hC0400000, 1'b0);

    beat(8'd254, 8'd254, 32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1);
    wait_out("overflow", 32'h7F800000, 1'b1);

    beat(8'd127, 8'd127, 32'h00000000, 32'h01010101, 1'b1);
    wait_out("zero", 32'h00000000, 1'b0);

    // backpressure: result held, extra beats refused
    m.out_ready = 1'b0;
    beat(8'd127, 8'd127, 32'h04030201, 32'h01010101, 1'b1);
    for (int i = 0; i < 20 && !m.out_valid; i++) tick();
    chk("bp_valid", 32'(m.out_valid), 32'd1);
    m.in_valid = 1'b1;
    m.in_last = 1'b1;
    m.in_exp_a = 8'd130;
    m.in_mant_a = 32'h7F7F7F7F;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", m.out_result, 32'h41200000);
      chk("bp_in_ready", 32'(m.in_ready), 32'd0);
      chk("bp_valid_hold", 32'(m.out_valid), 32'd1);
    end
    m.in_valid = 1'b0;
    m.in_last = 1'b0;
    m.out_ready = 1'b1;
    tick();
    chk("bp_release", 32'(m.out_valid), 32'd0);
    beat(8'd127, 8'd127, 32'h00000002, 32'h00000001, 1'b1);
    wait_out("after_bp", 32'h40000000, 1'b0);

    // reset mid-group drops the partial sum
    beat(8'd127, 8'd127, 32'h01010101, 32'h01010101, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_result", m.out_result, 32'd0);
    chk("midrst_valid", 32'(m.out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    beat(8'd127, 8'd127, 32'h00000001, 32'h00000001, 1'b1);
    wait_out("post_rst", 32'h3F800000, 1'b0);

    // 4096*4096 + 3*1 = 2^24+3: one dropped bit
`ifdef BFP_MAC_RNE_EN
    exp_rnd = 32'h4B800002;
`else
    exp_rnd = 32'h4B800001;
`endif
    r.in_exp_a = 8'd127;
    r.in_exp_b = 8'd127;
    r.in_mant_a = {16'd0, 16'd0, 16'd3, 16'd4096};
    r.in_mant_b = {16'd0, 16'd0, 16'd1, 16'd4096};
    r.in_last = 1'b1;
    r.in_valid = 1'b1;
    chk("rnd_in_ready", 32'(r.in_ready), 32'd1);
    tick();
    r.in_valid = 1'b0;
    r.in_last = 1'b0;
    for (int i = 0; i < 20 && !r.out_valid; i++) tick();
    chk("rnd_valid", 32'(r.out_valid), 32'd1);
    chk("rnd_result", r.out_result, exp_rnd);
    chk("rnd_ovf", 32'(r.out_overflow), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
